// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS instruction-format definitions.
//   - bit positions of every decode field in a 32-bit instruction word
//   - OP_RTYPE opcode value and the NOP_WORD encoding (sll $0,$0,0)
//   - instr_fields_t grouping of all decode fields
//   - sign_ext16: 16-to-32 sign extension matching the extensor block
package mips_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
  } instr_fields_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_field_split.sv
// mips_field_split: purely combinational slicing of a 32-bit MIPS word
// into its decode fields. Shared by the IF/ID stage and the decoder.
// Ports:
//   word   in  32  instruction word
//   fields out     instr_fields_t with opcode/rs/rt/rd/shamt/funct/imm16/jaddr
module mips_field_split
  import mips_pkg::*;
(
  input  logic [31:0]   word,
  output instr_fields_t fields
);

  assign fields.opcode = word[OPC_HI:OPC_LO];
  assign fields.rs     = word[RS_HI:RS_LO];
  assign fields.rt     = word[RT_HI:RT_LO];
  assign fields.rd     = word[RD_HI:RD_LO];
  assign fields.shamt  = word[SH_HI:SH_LO];
  assign fields.funct  = word[FN_HI:FN_LO];
  assign fields.imm16  = word[IMM_HI:IMM_LO];
  assign fields.jaddr  = word[JA_HI:JA_LO];

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register of the MIPS datapath.
// Takes a fetched instruction + PC over valid/ready, registers the word and
// PC+4, and exposes the decode fields as pure slices of the registered word.
// Flush (branch/jump taken) inserts a NOP bubble and drops any word offered
// in the same cycle. deliv_cnt counts completed output handshakes (wraps).
//
// Optional build macro IF_ID_SKID_EN: adds one skid entry so in_ready is a
// flop output with no combinational path from out_ready. Undefined: in_ready
// is the combinational !out_valid || out_ready.
//
// Ports:
//   clk, rst_n (async, active low)
//   in_valid/in_ready/in_instr/in_pc    fetch side handshake
//   flush                               discard held and incoming word
//   out_valid/out_ready                 decode side handshake
//   out_instr, out_pc_plus4             registered word and PC+4
//   opcode, rs, rt, rd, shamt, funct, imm16, jaddr  field slices
//   is_rtype                            opcode==0 gated by out_valid
//   deliv_cnt                           completed out handshakes
module if_id_stage
  import mips_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc_plus4,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      jaddr,
  output logic             is_rtype,
  output logic [CNT_W-1:0] deliv_cnt
);

  logic [31:0]      instr_reg;
  logic [PC_W-1:0]  pc4_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [PC_W-1:0]  in_pc_plus4;
  logic             accept;
  logic             drain;

  assign in_pc_plus4 = in_pc + PC_W'(4);
  assign drain       = valid_reg && out_ready;
  assign accept      = in_valid && in_ready && !flush;

`ifdef IF_ID_SKID_EN
  logic             skid_valid_reg;
  logic [31:0]      skid_instr_reg;
  logic [PC_W-1:0]  skid_pc4_reg;
  logic             out_free;

  // Registered ready: only the skid occupancy decides it.
  assign in_ready = !skid_valid_reg;
  assign out_free = !valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      instr_reg      <= NOP_WORD;
      pc4_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= NOP_WORD;
      skid_pc4_reg   <= '0;
    end else if (flush) begin
      valid_reg      <= 1'b0;
      instr_reg      <= NOP_WORD;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        // Older skid word goes first; no accept is possible this cycle.
        valid_reg      <= 1'b1;
        instr_reg      <= skid_instr_reg;
        pc4_reg        <= skid_pc4_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        valid_reg <= 1'b1;
        instr_reg <= in_instr;
        pc4_reg   <= in_pc_plus4;
      end else begin
        valid_reg <= 1'b0;
        instr_reg <= NOP_WORD;
      end
    end else if (accept) begin
      // Output is stalled: park the new word in the skid entry.
      skid_valid_reg <= 1'b1;
      skid_instr_reg <= in_instr;
      skid_pc4_reg   <= in_pc_plus4;
    end
  end
`else
  assign in_ready = !valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP_WORD;
      pc4_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP_WORD;
    end else if (accept) begin
      // Also covers accept-with-drain: new word replaces the old one.
      valid_reg <= 1'b1;
      instr_reg <= in_instr;
      pc4_reg   <= in_pc_plus4;
    end else if (drain) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP_WORD;
    end
  end
`endif

  // Counts even while flushing: decode already took the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (drain) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  instr_fields_t fields;

  mips_field_split u_split (
    .word   (instr_reg),
    .fields (fields)
  );

  assign out_valid    = valid_reg;
  assign out_instr    = instr_reg;
  assign out_pc_plus4 = pc4_reg;
  assign deliv_cnt    = cnt_reg;
  assign opcode       = fields.opcode;
  assign rs           = fields.rs;
  assign rt           = fields.rt;
  assign rd           = fields.rd;
  assign shamt        = fields.shamt;
  assign funct        = fields.funct;
  assign imm16        = fields.imm16;
  assign jaddr        = fields.jaddr;
  assign is_rtype     = valid_reg && (fields.opcode == OP_RTYPE);

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: self-checking bench for if_id_stage (CNT_W=4 so the
// counter wrap is reachable). Reference model: a FIFO of in-flight words
// (capacity 1 in base build, 2 with IF_ID_SKID_EN).
module tb_if_id_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        is_rtype;
  logic [3:0]  deliv_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc4[$];
  logic [3:0]  m_cnt;
  logic [31:0] got[$];

  if_id_stage #(.PC_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr),
    .is_rtype(is_rtype), .deliv_cnt(deliv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_in_ready(input logic ordy);
`ifdef IF_ID_SKID_EN
    return mq_instr.size() < 2;
`else
    return (mq_instr.size() == 0) || ordy;
`endif
  endfunction

  // Drive one cycle of stimulus, log deliveries, advance the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    logic deliver;
    logic acc;
    in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    deliver = (mq_instr.size() > 0) && ordy;
    acc     = v && m_in_ready(ordy) && !fl;
    if (out_valid && out_ready) begin
      got.push_back(out_instr);
      $display("deliver instr=%h pc4=%h flush=%0b", out_instr, out_pc_plus4, fl);
    end
    @(posedge clk);
    if (deliver) m_cnt = m_cnt + 4'd1;
    if (fl) begin
      mq_instr.delete(); mq_pc4.delete();
    end else begin
      if (deliver) begin void'(mq_instr.pop_front()); void'(mq_pc4.pop_front()); end
      if (acc) begin mq_instr.push_back(ins); mq_pc4.push_back(pc + 32'd4); end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; in_instr = 0; in_pc = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    mq_instr.delete(); mq_pc4.delete(); m_cnt = 0; got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", out_pc_plus4); end
    checks++; if (deliv_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", deliv_cnt); end
    cycle(1, 32'h2008_0001, 32'h40, 0, 1);
    cycle(1, 32'h2008_0002, 32'h44, 0, 1);
    checks++; if (deliv_cnt !== 4'd1 || out_valid !== 1'b1) begin errors++;
      $display("FAIL pre_reset_state got cnt=%0d v=%b exp cnt=1 v=1", deliv_cnt, out_valid); end
    rst_n = 0; #1;  // mid-cycle, no clock edge before checking
    checks++; if ({out_valid, out_instr, deliv_cnt} !== {1'b0, 32'h0, 4'd0}) begin errors++;
      $display("FAIL async_reset got v=%b i=%h c=%0d exp v=0 i=0 c=0", out_valid, out_instr, deliv_cnt); end
    mq_instr.delete(); mq_pc4.delete(); m_cnt = 0; got.delete();
    in_valid = 0; out_ready = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    do_reset();
    cycle(1, 32'h2008ABEA, 32'h100, 0, 1);
    in_valid = 0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL itype_valid got %b exp 1", out_valid); end
    checks++; if (opcode !== 6'h08) begin errors++; $display("FAIL itype_opcode got %h exp 08", opcode); end
    checks++; if (rt !== 5'd8) begin errors++; $display("FAIL itype_rt got %0d exp 8", rt); end
    checks++; if (imm16 !== 16'hABEA) begin errors++; $display("FAIL itype_imm16 got %h exp abea", imm16); end
    checks++; if (sign_ext16(imm16) !== 32'hFFFFABEA) begin errors++;
      $display("FAIL itype_ext got %h exp ffffabea", sign_ext16(imm16)); end
    checks++; if (out_pc_plus4 !== 32'h104) begin errors++; $display("FAIL itype_pc4 got %h exp 104", out_pc_plus4); end
    checks++; if (is_rtype !== 1'b0) begin errors++; $display("FAIL itype_isr got %b exp 0", is_rtype); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (deliv_cnt !== 4'd1) begin errors++; $display("FAIL itype_cnt got %0d exp 1", deliv_cnt); end
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++;
      $display("FAIL itype_drain got v=%b i=%h exp v=0 i=0", out_valid, out_instr); end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1, 32'h012A4020, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 0; out_ready = 0; #1;
      checks++; if ({is_rtype, rs, rt, rd, funct} !== {1'b1, 5'd9, 5'd10, 5'd8, 6'h20}) begin errors++;
        $display("FAIL stall_fields got r=%b rs=%0d rt=%0d rd=%0d fn=%h exp r=1 rs=9 rt=10 rd=8 fn=20",
                 is_rtype, rs, rt, rd, funct); end
      checks++; if (out_instr !== 32'h012A4020 || out_pc_plus4 !== 32'h204 || out_valid !== 1'b1) begin errors++;
        $display("FAIL stall_hold got i=%h pc4=%h v=%b exp i=012a4020 pc4=204 v=1", out_instr, out_pc_plus4, out_valid); end
`ifdef IF_ID_SKID_EN
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready got %b exp 1", in_ready); end
`else
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
`endif
      checks++; if (deliv_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt got %0d exp 0", deliv_cnt); end
      cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 1);
    checks++; if (deliv_cnt !== 4'd1) begin errors++; $display("FAIL stall_release_cnt got %0d exp 1", deliv_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 32'h2009_0007, 32'h300, 0, 0);
    cycle(1, 32'h08000040, 32'h304, 1, 0);
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++;
      $display("FAIL flush_bubble got v=%b i=%h exp v=0 i=0", out_valid, out_instr); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1);
      checks++; if (out_valid !== 1'b0 || out_instr === 32'h08000040) begin errors++;
        $display("FAIL flush_drop got v=%b i=%h exp v=0 i=0", out_valid, out_instr); end
    end
    checks++; if (deliv_cnt !== 4'd0) begin errors++; $display("FAIL flush_cnt0 got %0d exp 0", deliv_cnt); end
    cycle(1, 32'h200A_0001, 32'h400, 0, 0);
    cycle(1, 32'h08000040, 32'h404, 1, 1);  // consumed word during flush still counts
    checks++; if (deliv_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_count got cnt=%0d v=%b exp cnt=1 v=0", deliv_cnt, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[5];
    logic        pat[5];
    logic        r0, r1;
    int idx;
    int cyc;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    idx = 0; cyc = 0;
    while (got.size() < 5 && cyc < 60) begin
      in_valid = (idx < 5); out_ready = pat[cyc % 5]; #1;
      checks++; if (in_ready !== m_in_ready(out_ready)) begin errors++;
        $display("FAIL b2b_in_ready got %b exp %b", in_ready, m_in_ready(out_ready)); end
      if (idx < 5 && m_in_ready(out_ready)) begin
        cycle(1, w[idx], 32'h1000 + 32'(idx) * 4, 0, pat[cyc % 5]);
        idx++;
      end else begin
        cycle(0, 0, 0, 0, pat[cyc % 5]);
      end
      cyc++;
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] !== w[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, got[i], w[i]); end
    end
    checks++; if (deliv_cnt !== 4'd5) begin errors++; $display("FAIL b2b_cnt got %0d exp 5", deliv_cnt); end
    // With a word held, flip out_ready within one cycle and watch in_ready.
    cycle(1, 32'hCAFE_0001, 32'h2000, 0, 0);
    in_valid = 0; out_ready = 0; #1; r0 = in_ready;
    out_ready = 1; #1; r1 = in_ready;
`ifdef IF_ID_SKID_EN
    checks++; if (r1 !== r0) begin errors++; $display("FAIL skid_comb_path got %b exp %b", r1, r0); end
`else
    checks++; if ({r0, r1} !== 2'b01) begin errors++; $display("FAIL base_comb_path got %b%b exp 01", r0, r1); end
`endif
    out_ready = 0;
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, $urandom, {$urandom_range(0, 1000), 2'b00}, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++; if (deliv_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap got %0d exp 1", deliv_cnt); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    cycle(1, 32'h2008_0003, 32'hFFFFFFFC, 0, 1);
    checks++; if (out_pc_plus4 !== 32'h0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL pc_wrap got pc4=%h v=%b exp pc4=0 v=1", out_pc_plus4, out_valid); end
  endtask

  task automatic test_random();
    logic        v, fl, ordy;
    logic [31:0] ins, pc, exp_i;
    logic        exp_v;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 9) < 7); fl = ($urandom_range(0, 19) == 0); ordy = ($urandom_range(0, 9) < 6);
      ins = $urandom; pc = {$urandom, 2'b00};
      in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy; #1;
      exp_v = (mq_instr.size() > 0);
      exp_i = exp_v ? mq_instr[0] : 32'h0;
      checks++; if (in_ready !== m_in_ready(ordy)) begin errors++;
        $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, in_ready, m_in_ready(ordy)); end
      checks++; if (out_valid !== exp_v || out_instr !== exp_i) begin errors++;
        $display("FAIL rnd_out n=%0d got v=%b i=%h exp v=%b i=%h", n, out_valid, out_instr, exp_v, exp_i); end
      checks++; if ({opcode, rs, rt, rd, shamt, funct} !== exp_i || imm16 !== exp_i[15:0] || jaddr !== exp_i[25:0]) begin errors++;
        $display("FAIL rnd_fields n=%0d got %h exp %h", n, {opcode, rs, rt, rd, shamt, funct}, exp_i); end
      checks++; if (is_rtype !== (exp_v && exp_i[31:26] == 6'd0)) begin errors++;
        $display("FAIL rnd_isr n=%0d got %b", n, is_rtype); end
      checks++; if (deliv_cnt !== m_cnt) begin errors++;
        $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, deliv_cnt, m_cnt); end
      if (exp_v) begin
        checks++; if (out_pc_plus4 !== mq_pc4[0]) begin errors++;
          $display("FAIL rnd_pc4 n=%0d got %h exp %h", n, out_pc_plus4, mq_pc4[0]); end
      end
      cycle(v, ins, pc, fl, ordy);
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; in_instr = 0; in_pc = 0; m_cnt = 0;
    test_reset();
    test_itype();
    test_stall();
    test_flush();
    test_back_to_back();
    test_counter_wrap();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode in the MIPS datapath.
- Accepts a fetched 32-bit instruction plus its PC over a valid/ready handshake.
- Registers the instruction and splits it into decode fields. imm16 drives the 16-to-32 sign extender (extensor) directly.
- Supports stall via backpressure, flush (branch/jump taken) with NOP bubble insertion, and a wrap-around count of instructions delivered.

Parameters:
- PC_W, 32, width of PC and pc_plus4.
- CNT_W, 16, width of delivered-instruction counter.
- NOP_WORD, 32'h0000_0000, encoding loaded on reset/flush (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  address of in_instr.
- flush  input  1  discard held and incoming instruction.
- out_valid  output  1  registered instruction is valid.
- out_ready  input  1  decode consumes this cycle.
- out_instr  output  32  registered instruction.
- out_pc_plus4  output  PC_W  registered in_pc + 4.
- opcode  output  6  out_instr[31:26].
- rs  output  5  out_instr[25:21].
- rt  output  5  out_instr[20:16].
- rd  output  5  out_instr[15:11].
- shamt  output  5  out_instr[10:6].
- funct  output  6  out_instr[5:0].
- imm16  output  16  out_instr[15:0]; feeds extensor input.
- jaddr  output  26  out_instr[25:0].
- is_rtype  output  1  opcode == 6'b000000, gated by out_valid.
- deliv_cnt  output  CNT_W  number of completed out handshakes.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_instr=NOP_WORD, out_pc_plus4=0, deliv_cnt=0. Outputs reach these values immediately, without waiting for a clock edge. Release is synchronised by the surrounding design.
- Field outputs are pure slices of out_instr; no extra latency. is_rtype=0 whenever out_valid=0.
- Base mode: in_ready = !out_valid || out_ready (combinational pass-through of backpressure).
- Accept (in_valid && in_ready && !flush): next edge loads out_instr=in_instr, out_pc_plus4=in_pc+4 (mod 2^PC_W), out_valid=1.
- Latency: 1 cycle from accept to out_valid.
- Drain (out_valid && out_ready, no accept): out_valid=0 and out_instr=NOP_WORD next edge.
- Stall (out_valid && !out_ready): out_instr, out_pc_plus4 and out_valid held bit-stable.
- Flush has priority over everything. The next edge forces out_valid=0 and out_instr=NOP_WORD, and drops any incoming instruction offered in the same cycle. in_ready is unaffected by flush; a handshake that fires during flush is consumed and discarded.
- Counter: deliv_cnt increments on each out_valid && out_ready edge, including the cycle flush is asserted (decode has already consumed it). Wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and drain: the new word replaces the old; the counter increments; out_valid stays 1.
- Reset mid-stall or mid-transfer: the held instruction is lost and the counter is cleared. There is no replay.

Optional Feature:
- Macro: IF_ID_SKID_EN.
- Defined: adds one skid entry so in_ready is a flop output, with no combinational path from out_ready.
  - in_ready = skid empty.
  - An accept during a stall lands in the skid. On the next drain the skid moves to the output register.
  - Flush clears both entries.
  - Order is preserved; latency is still 1 cycle when unstalled.
- Undefined: base combinational in_ready as above.

Decomposition:
- Package mips_pkg holds:
  - field bit-position localparams (OPC_HI/LO, RS_HI/LO, etc.);
  - the OP_RTYPE constant;
  - the NOP_WORD constant;
  - an instr_fields_t-style grouping of opcode/rs/rt/rd/shamt/funct/imm16/jaddr.
- One natural sub-module: mips_field_split (combinational slicing of a 32-bit word into fields). It is reused later by the decoder and the instantiating stage.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, out_instr=0, deliv_cnt=0 immediately, with no clock edge needed.
- Single I-type transfer: in_instr=32'h2008ABEA (addi $8,$0,0xABEA), in_pc=0x100, out_ready=1 -> next cycle:
  - out_valid=1, opcode=6'h08, rt=8, imm16=16'hABEA;
  - out_pc_plus4=0x104;
  - extensor out=32'hFFFFABEA;
  - deliv_cnt=1 after handshake.
- Stall: out_ready=0 for 3 cycles holding 32'h012A4020 (add $8,$9,$10) -> fields stable, is_rtype=1, rs=9, rt=10, rd=8, funct=6'h20, in_ready=0 (base mode), deliv_cnt unchanged.
- Flush with concurrent offer: flush=1 while in_valid=1 with 32'h08000040 -> next cycle out_valid=0, out_instr=0; the offered word never appears.
- Back-to-back stream of 5 words with out_ready toggling 1,0,1,1,0 -> delivered in order, no duplicates/drops, deliv_cnt=5. With IF_ID_SKID_EN, in_ready never depends combinationally on out_ready.
- Counter wrap: CNT_W=4, deliver 17 instructions -> deliv_cnt=1. PC wrap: in_pc=32'hFFFFFFFC -> out_pc_plus4=0.
